ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pkg.sv | 75 +++++++
 rtl/ctrl_pipe_if.sv | 34 +++
 rtl/ctrl_decode.sv | 98 +++++++++
 rtl/ctrl_pipe.sv | 130 +++++++++++++
 tb/tb_ctrl_pipe.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the EX/WB control pipeline: ALU op codes, opcodes, WB selects and the
// decoded control bundle carried from decode into the EX stage register.
package ctrl_pkg;

  typedef enum logic [4:0] {
    AluAdd    = 5'd0,
    AluSub    = 5'd1,
    AluSll    = 5'd2,
    AluSlt    = 5'd3,
    AluSltu   = 5'd4,
    AluXor    = 5'd5,
    AluSrl    = 5'd6,
    AluSra    = 5'd7,
    AluOr     = 5'd8,
    AluAnd    = 5'd9,
    AluLui    = 5'd10,
    AluMul    = 5'd11,
    AluAuipc  = 5'd13,
    AluMulh   = 5'd14,
    AluMulhsu = 5'd15,
    AluMulhu  = 5'd16,
    AluDiv    = 5'd17,
    AluDivu   = 5'd18,
    AluRem    = 5'd19,
    AluRemu   = 5'd20
  } aluop_e;

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcI      = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  localparam logic [1:0] WbAlu = 2'b00;
  localparam logic [1:0] WbMem = 2'b01;
  localparam logic [1:0] WbPc4 = 2'b10;

  // sel_a: operand A is the PC; sel_b: operand B is the immediate.
  typedef struct packed {
    aluop_e     aluop;
    logic       sel_a;
    logic       sel_b;
    logic       rd_en;
    logic       wd_en;
    logic       br_type;
    logic       jump_en;
    logic       rf_en;
    logic [1:0] wb_sel;
    logic       is_mul;
    logic       is_div;
  } ctrl_bundle_t;

  typedef enum logic [1:0] {StRun, StMdu, StHalt} state_e;

  // Base integer op selected by func3 (func7 = 0000000 encodings).
  function automatic aluop_e alu_base(logic [2:0] f3);
    aluop_e op;
    case (f3)
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = AluSrl;
      3'b110:  op = AluOr;
      3'b111:  op = AluAnd;
      default: op = AluAdd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Decode-side handshake and EX/WB control outputs of ctrl_pipe.
interface ctrl_pipe_if;
  logic       instr_valid;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       flush;
  logic       instr_ready;
  logic       ex_valid;
  logic [4:0] ex_aluop;
  logic       ex_sel_a;
  logic       ex_sel_b;
  logic       ex_rd_en;
  logic       ex_wd_en;
  logic       ex_br_type;
  logic       ex_jump_en;
  logic       ex_mdu_busy;
  logic       wb_valid;
  logic       wb_rf_en;
  logic [1:0] wb_sel;
  logic       illegal;

  modport master (
    output instr_valid, opcode, func3, func7, flush,
    input  instr_ready, ex_valid, ex_aluop, ex_sel_a, ex_sel_b, ex_rd_en, ex_wd_en,
           ex_br_type, ex_jump_en, ex_mdu_busy, wb_valid, wb_rf_en, wb_sel, illegal
  );

  modport slave (
    input  instr_valid, opcode, func3, func7, flush,
    output instr_ready, ex_valid, ex_aluop, ex_sel_a, ex_sel_b, ex_rd_en, ex_wd_en,
           ex_br_type, ex_jump_en, ex_mdu_busy, wb_valid, wb_rf_en, wb_sel, illegal
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational RV32I(+M) control decoder; any unrecognised encoding raises illegal_o and
// returns an all-zero bundle.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit EN_M = 1'b1
) (
  input  logic [6:0]   opcode_i,
  input  logic [2:0]   func3_i,
  input  logic [6:0]   func7_i,
  output ctrl_bundle_t ctrl_o,
  output logic         illegal_o
);

  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    case (opcode_i)
      OpcR: begin
        ctrl_o.rf_en = 1'b1;
        if (func7_i == 7'b0000000) begin
          ctrl_o.aluop = alu_base(func3_i);
        end else if (func7_i == 7'b0100000 && func3_i == 3'b000) begin
          ctrl_o.aluop = AluSub;
        end else if (func7_i == 7'b0100000 && func3_i == 3'b101) begin
          ctrl_o.aluop = AluSra;
        end else if (func7_i == 7'b0000001 && EN_M) begin
          ctrl_o.is_mul = ~func3_i[2];
          ctrl_o.is_div = func3_i[2];
          case (func3_i)
            3'b000:  ctrl_o.aluop = AluMul;
            3'b001:  ctrl_o.aluop = AluMulh;
            3'b010:  ctrl_o.aluop = AluMulhsu;
            3'b011:  ctrl_o.aluop = AluMulhu;
            3'b100:  ctrl_o.aluop = AluDiv;
            3'b101:  ctrl_o.aluop = AluDivu;
            3'b110:  ctrl_o.aluop = AluRem;
            default: ctrl_o.aluop = AluRemu;
          endcase
        end else begin
          illegal_o = 1'b1;
        end
      end
      OpcI: begin
        ctrl_o.rf_en = 1'b1;
        ctrl_o.sel_b = 1'b1;
        ctrl_o.aluop = alu_base(func3_i);
        // Shift-immediates reuse func7 as an opcode extension.
        if (func3_i == 3'b001 && func7_i != 7'b0000000) begin
          illegal_o = 1'b1;
        end else if (func3_i == 3'b101) begin
          if (func7_i == 7'b0100000) ctrl_o.aluop = AluSra;
          else if (func7_i != 7'b0000000) illegal_o = 1'b1;
        end
      end
      OpcLoad: begin
        ctrl_o.rd_en  = 1'b1;
        ctrl_o.rf_en  = 1'b1;
        ctrl_o.sel_b  = 1'b1;
        ctrl_o.wb_sel = WbMem;
        illegal_o     = (func3_i == 3'b011) || (func3_i[2:1] == 2'b11);
      end
      OpcStore: begin
        ctrl_o.wd_en = 1'b1;
        ctrl_o.sel_b = 1'b1;
        illegal_o    = (func3_i > 3'b010);
      end
      OpcBranch: begin
        ctrl_o.br_type = 1'b1;
        ctrl_o.sel_a   = 1'b1;
        ctrl_o.sel_b   = 1'b1;
        illegal_o      = (func3_i[2:1] == 2'b01);
      end
      OpcLui: begin
        ctrl_o.aluop = AluLui;
        ctrl_o.rf_en = 1'b1;
        ctrl_o.sel_b = 1'b1;
      end
      OpcAuipc: begin
        ctrl_o.aluop = AluAuipc;
        ctrl_o.rf_en = 1'b1;
        ctrl_o.sel_a = 1'b1;
        ctrl_o.sel_b = 1'b1;
      end
      OpcJal, OpcJalr: begin
        ctrl_o.rf_en   = 1'b1;
        ctrl_o.jump_en = 1'b1;
        ctrl_o.sel_a   = (opcode_i == OpcJal);
        ctrl_o.sel_b   = 1'b1;
        ctrl_o.wb_sel  = WbPc4;
        illegal_o      = (opcode_i == OpcJalr) && (func3_i != 3'b000);
      end
      default: illegal_o = 1'b1;
    endcase
    if (illegal_o) ctrl_o = '0;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// EX/WB control pipeline: accepts decoded instructions, holds multi-cycle M ops in EX for
// their full latency, retires into a one-cycle WB pulse, and halts on an illegal instruction.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 8,
  parameter bit          EN_M    = 1'b1
) (
  input logic        clk,
  input logic        rst,
  ctrl_pipe_if.slave bus
);

  localparam logic [3:0] MulLast = 4'(MUL_LAT - 1);
  localparam logic [3:0] DivLast = 4'(DIV_LAT - 1);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         ex_valid_q, ex_valid_d;
  ctrl_bundle_t ex_q, ex_d;
  logic         wb_valid_q, wb_valid_d;
  logic         wb_rf_en_q, wb_rf_en_d;
  logic [1:0]   wb_sel_q, wb_sel_d;
  logic         illegal_q, illegal_d;

  ctrl_bundle_t dec;
  logic         dec_illegal;
  logic         busy, accept;

  ctrl_decode #(.EN_M(EN_M)) u_decode (
    .opcode_i  (bus.opcode),
    .func3_i   (bus.func3),
    .func7_i   (bus.func7),
    .ctrl_o    (dec),
    .illegal_o (dec_illegal)
  );

  // In MDU the counter is always below L-1; the last EX cycle is spent back in RUN.
  assign busy            = ex_valid_q && (state_q == StMdu);
  assign bus.instr_ready = !rst && (state_q == StRun) && !bus.flush && !busy;
  assign accept          = bus.instr_valid && bus.instr_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    wb_valid_d = 1'b0;
    wb_rf_en_d = 1'b0;
    wb_sel_d   = WbAlu;
    illegal_d  = illegal_q;

    if (ex_valid_q && !busy && !bus.flush) begin
      wb_valid_d = 1'b1;
      wb_rf_en_d = ex_q.rf_en;
      wb_sel_d   = ex_q.wb_sel;
    end
    if ((ex_valid_q && !busy) || bus.flush) begin
      ex_valid_d = 1'b0;
      ex_d       = '0;
    end

    case (state_q)
      StRun: begin
        if (accept) begin
          if (dec_illegal) begin
            illegal_d = 1'b1;
            state_d   = StHalt;
          end else begin
            ex_valid_d = 1'b1;
            ex_d       = dec;
            cnt_d      = '0;
            if ((dec.is_mul && MUL_LAT > 32'd1) || (dec.is_div && DIV_LAT > 32'd1)) begin
              state_d = StMdu;
            end
          end
        end
      end
      StMdu: begin
        if (bus.flush) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == (ex_q.is_div ? DivLast : MulLast)) state_d = StRun;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      cnt_q      <= '0;
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rf_en_q <= 1'b0;
      wb_sel_q   <= WbAlu;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
      wb_valid_q <= wb_valid_d;
      wb_rf_en_q <= wb_rf_en_d;
      wb_sel_q   <= wb_sel_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_aluop    = ex_q.aluop;
  assign bus.ex_sel_a    = ex_q.sel_a;
  assign bus.ex_sel_b    = ex_q.sel_b;
  assign bus.ex_rd_en    = ex_q.rd_en;
  assign bus.ex_wd_en    = ex_q.wd_en;
  assign bus.ex_br_type  = ex_q.br_type;
  assign bus.ex_jump_en  = ex_q.jump_en;
  assign bus.ex_mdu_busy = busy;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_rf_en    = wb_rf_en_q;
  assign bus.wb_sel      = wb_sel_q;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboarded random test of ctrl_pipe against a behavioural model, plus a small directed
// check of an EN_M=0 instance.
module tb_ctrl_pipe;

  localparam int MulLat = 2;
  localparam int DivLat = 8;

  typedef struct {
    bit ill;
    int alu;
    bit sa, sb, rd, wd, br, jmp, rf;
    int sel;
    int lat;
  } ref_t;

  typedef struct {
    bit rf;
    int sel;
  } wb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst0 = 1'b1;
  always #5 clk = ~clk;

  ctrl_pipe_if ifc ();
  ctrl_pipe_if ifc0 ();

  ctrl_pipe #(.MUL_LAT(MulLat), .DIV_LAT(DivLat), .EN_M(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  ctrl_pipe #(.MUL_LAT(MulLat), .DIV_LAT(DivLat), .EN_M(1'b0)) u_dut_nom (
    .clk (clk),
    .rst (rst0),
    .bus (ifc0.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: remaining EX cycles of the resident op, halt flag, pending WB results.
  bit   halted = 1'b0;
  int   ex_left = 0;
  ref_t ex_cur;
  wb_t  wb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Straight from the instruction-set tables: class by opcode, op by func3 lookup.
  function automatic ref_t ref_decode(bit [6:0] op, bit [2:0] f3, bit [6:0] f7, bit en_m);
    int   base[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int   mops[8] = '{11, 14, 15, 16, 17, 18, 19, 20};
    ref_t r;
    r = '{ill: 1'b1, alu: 0, sa: 0, sb: 0, rd: 0, wd: 0, br: 0, jmp: 0, rf: 0, sel: 0, lat: 1};
    case (op)
      7'b0110011: begin
        r.rf = 1;
        if (f7 == 7'h00) begin r.ill = 0; r.alu = base[f3]; end
        else if (f7 == 7'h20 && f3 == 0) begin r.ill = 0; r.alu = 1; end
        else if (f7 == 7'h20 && f3 == 5) begin r.ill = 0; r.alu = 7; end
        else if (f7 == 7'h01 && en_m) begin
          r.ill = 0; r.alu = mops[f3]; r.lat = (f3 < 4) ? MulLat : DivLat;
        end
      end
      7'b0010011: begin
        r.rf = 1; r.sb = 1; r.alu = base[f3];
        if (f3 == 1) r.ill = (f7 != 0);
        else if (f3 == 5) begin r.ill = !(f7 == 0 || f7 == 7'h20); if (f7 == 7'h20) r.alu = 7; end
        else r.ill = 0;
      end
      7'b0000011: begin
        r.rd = 1; r.rf = 1; r.sb = 1; r.sel = 1;
        r.ill = !(f3 inside {0, 1, 2, 4, 5});
      end
      7'b0100011: begin r.wd = 1; r.sb = 1; r.ill = (f3 > 2); end
      7'b1100011: begin r.br = 1; r.sa = 1; r.sb = 1; r.ill = (f3 == 2 || f3 == 3); end
      7'b0110111: begin r.ill = 0; r.alu = 10; r.rf = 1; r.sb = 1; end
      7'b0010111: begin r.ill = 0; r.alu = 13; r.rf = 1; r.sa = 1; r.sb = 1; end
      7'b1101111: begin r.ill = 0; r.rf = 1; r.jmp = 1; r.sa = 1; r.sb = 1; r.sel = 2; end
      7'b1100111: begin r.ill = (f3 != 0); r.rf = 1; r.jmp = 1; r.sb = 1; r.sel = 2; end
      default: r.ill = 1;
    endcase
    return r;
  endfunction

  // Reference model, stepped on every clock edge or reset.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      halted  = 0;
      ex_left = 0;
      wb_q.delete();
    end else begin : step
      bit   rdy;
      ref_t d;
      rdy = !halted && !ifc.flush && ex_left <= 1;
      if (ifc.flush) ex_left = 0;
      else if (ex_left == 1) begin wb_q.push_back('{ex_cur.rf, ex_cur.sel}); ex_left = 0; end
      else if (ex_left > 1) ex_left--;
      if (rdy && ifc.instr_valid) begin
        d = ref_decode(ifc.opcode, ifc.func3, ifc.func7, 1'b1);
        if (d.ill) halted = 1;
        else begin ex_left = d.lat; ex_cur = d; end
      end
    end
  end

  // Monitor: compares DUT outputs against the model and pops WB expectations.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("instr_ready", 32'(ifc.instr_ready), 32'(!halted && !ifc.flush && ex_left <= 1));
      check("ex_valid", 32'(ifc.ex_valid), 32'(ex_left > 0));
      check("ex_mdu_busy", 32'(ifc.ex_mdu_busy), 32'(ex_left > 1));
      check("illegal", 32'(ifc.illegal), 32'(halted));
      if (ex_left > 0)
        check("ex_bundle",
              32'({ifc.ex_aluop, ifc.ex_sel_a, ifc.ex_sel_b, ifc.ex_rd_en, ifc.ex_wd_en,
                   ifc.ex_br_type, ifc.ex_jump_en}),
              32'({5'(ex_cur.alu), ex_cur.sa, ex_cur.sb, ex_cur.rd, ex_cur.wd, ex_cur.br,
                   ex_cur.jmp}));
      else
        check("ex_idle_zero",
              32'({ifc.ex_aluop, ifc.ex_sel_a, ifc.ex_sel_b, ifc.ex_rd_en, ifc.ex_wd_en,
                   ifc.ex_br_type, ifc.ex_jump_en}), 32'd0);
      if (ifc.wb_valid) begin
        if (wb_q.size() == 0) check("wb_unexpected", 32'(ifc.wb_valid), 32'd0);
        else begin : pop
          wb_t w;
          w = wb_q.pop_front();
          check("wb_bundle", 32'({ifc.wb_rf_en, ifc.wb_sel}), 32'({w.rf, 2'(w.sel)}));
        end
      end else begin
        check("wb_rf_en_idle", 32'(ifc.wb_rf_en), 32'd0);
        check("wb_missing", 32'(wb_q.size()), 32'd0);
      end
    end
  end

  function automatic logic [17:0] outs(input bit which);
    if (which)
      return {ifc0.ex_valid, ifc0.ex_aluop, ifc0.ex_sel_a, ifc0.ex_sel_b, ifc0.ex_rd_en,
              ifc0.ex_wd_en, ifc0.ex_br_type, ifc0.ex_jump_en, ifc0.ex_mdu_busy,
              ifc0.wb_valid, ifc0.wb_rf_en, ifc0.wb_sel, ifc0.illegal, ifc0.instr_ready};
    return {ifc.ex_valid, ifc.ex_aluop, ifc.ex_sel_a, ifc.ex_sel_b, ifc.ex_rd_en,
            ifc.ex_wd_en, ifc.ex_br_type, ifc.ex_jump_en, ifc.ex_mdu_busy, ifc.wb_valid,
            ifc.wb_rf_en, ifc.wb_sel, ifc.illegal, ifc.instr_ready};
  endfunction

  task automatic drive(input bit v, input bit [6:0] op, input bit [2:0] f3,
                       input bit [6:0] f7, input bit fl);
    @(posedge clk);
    #1;
    ifc.instr_valid = v;
    ifc.opcode      = op;
    ifc.func3       = f3;
    ifc.func7       = f7;
    ifc.flush       = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 7'h00, 3'd0, 7'h00, 1'b0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1 check("async_rst_outputs", 32'(outs(1'b0)), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic gen(output bit [6:0] op, output bit [2:0] f3, output bit [6:0] f7);
    bit [2:0] ld_f3[5] = '{0, 1, 2, 4, 5};
    bit [2:0] br_f3[6] = '{0, 1, 4, 5, 6, 7};
    bit [6:0] ops[6]   = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b0000011, 7'b0100011,
                           7'b1100011};
    int k;
    f3 = 3'($urandom);
    f7 = 7'($urandom);
    k  = $urandom_range(0, 19);
    if (k == 0) begin op = 7'($urandom); return; end
    if (k <= 7) begin
      op = 7'b0110011;
      f7 = (k <= 3) ? 7'h00 : (k <= 5) ? 7'h01 : 7'h20;
      if (f7 == 7'h20) f3 = $urandom_range(0, 1) ? 3'd0 : 3'd5;
    end else if (k <= 10) begin
      op = 7'b0010011;
      if (f3 == 1) f7 = 7'h00;
      if (f3 == 5) f7 = $urandom_range(0, 1) ? 7'h00 : 7'h20;
    end else if (k == 11) begin
      op = 7'b1100111; f3 = 3'd0;
    end else begin
      op = ops[$urandom_range(0, 5)];
      if (op == 7'b0000011) f3 = ld_f3[$urandom_range(0, 4)];
      if (op == 7'b0100011) f3 = 3'($urandom_range(0, 2));
      if (op == 7'b1100011) f3 = br_f3[$urandom_range(0, 5)];
    end
  endtask

  initial begin
    bit [6:0] op;
    bit [2:0] f3;
    bit [6:0] f7;
    ifc.instr_valid = 0; ifc.opcode = 0; ifc.func3 = 0; ifc.func7 = 0; ifc.flush = 0;
    ifc0.instr_valid = 0; ifc0.opcode = 0; ifc0.func3 = 0; ifc0.func7 = 0; ifc0.flush = 0;
    idle(2);
    check("reset_outputs", 32'(outs(1'b0)), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // ADD, then MUL followed by a held ADD.
    drive(1, 7'b0110011, 3'd0, 7'h00, 0);
    idle(3);
    drive(1, 7'b0110011, 3'd0, 7'h01, 0);
    drive(1, 7'b0110011, 3'd0, 7'h00, 0);
    drive(1, 7'b0110011, 3'd0, 7'h00, 0);
    idle(3);

    // DIV flushed in its 4th EX cycle, then flush beating an illegal opcode.
    drive(1, 7'b0110011, 3'd4, 7'h01, 0);
    idle(3);
    drive(0, 7'h00, 3'd0, 7'h00, 1);
    drive(1, 7'h7f, 3'd0, 7'h00, 1);
    idle(4);

    // Illegal opcode halts until reset.
    drive(1, 7'h7f, 3'd0, 7'h00, 0);
    for (int i = 0; i < 20; i++) drive(1, 7'b0110011, 3'd0, 7'h00, 0);
    async_reset();
    idle(3);

    // Reset during DIV cycle 3 discards it.
    drive(1, 7'b0110011, 3'd4, 7'h01, 0);
    idle(3);
    async_reset();
    idle(12);

    for (int e = 0; e < 40; e++) begin
      for (int c = 0; c < 80; c++) begin
        gen(op, f3, f7);
        drive($urandom_range(0, 9) < 7, op, f3, f7, $urandom_range(0, 19) == 0);
        if ($urandom_range(0, 149) == 0) async_reset();
      end
      async_reset();
    end
    idle(12);
    check("wb_drain", 32'(wb_q.size()), 32'd0);

    // EN_M=0 instance.
    @(posedge clk);
    #2 rst0 = 1'b0;
    @(posedge clk); #1;
    ifc0.instr_valid = 1; ifc0.opcode = 7'b0110011; ifc0.func3 = 0; ifc0.func7 = 7'h01;
    @(posedge clk); #1 ifc0.instr_valid = 0;
    @(negedge clk);
    check("nom_mul_illegal", 32'({ifc0.illegal, ifc0.instr_ready, ifc0.ex_valid}), 32'b100);
    #2 rst0 = 1'b1;
    @(posedge clk); #2 rst0 = 1'b0;
    @(posedge clk); #1;
    ifc0.instr_valid = 1; ifc0.opcode = 7'b0000011; ifc0.func3 = 3'd2;
    @(posedge clk); #1;
    ifc0.opcode = 7'b1100111; ifc0.func3 = 3'd0;
    @(negedge clk);
    check("nom_lw_ex", 32'({ifc0.ex_valid, ifc0.ex_rd_en, ifc0.ex_aluop}), 32'h60);
    @(posedge clk); #1 ifc0.instr_valid = 0;
    @(negedge clk);
    check("nom_lw_wb", 32'({ifc0.wb_valid, ifc0.wb_rf_en, ifc0.wb_sel}), 32'b1101);
    check("nom_jalr_ex", 32'({ifc0.ex_valid, ifc0.ex_jump_en, ifc0.ex_rd_en}), 32'b110);
    @(negedge clk);
    check("nom_jalr_wb", 32'({ifc0.wb_valid, ifc0.wb_rf_en, ifc0.wb_sel}), 32'b1110);
    check("nom_illegal_clear", 32'(ifc0.illegal), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
